// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the CPU external data bus.
//
// Master 0 is the CPU memory stage and master 1 is a secondary requester (DMA/debug
// loader). Ownership is granted round-robin. A master may keep the bus for at most
// BURST_MAX consecutive accesses while the other master is waiting. Read data arrives
// from the slave one cycle after the access. It is routed back to the master that
// issued the read, even if ownership has changed in the meantime.
//
// Ports:
//   clock, reset            - system clock (rising edge); asynchronous active-high reset
//   req0/we0/addr0/wdata0   - master 0 request, write enable, address and write data
//   gnt0                    - master 0 owns the bus
//   rvalid0/rdata0          - master 0 read-return pulse and data
//   req1 .. rdata1          - the same set of signals for master 1
//   cs/we/ADDR              - slave chip select, write enable and address
//   Data_BUS_WRITE          - slave write data
//   Data_BUS_READ           - slave read data, valid the cycle after a read access

module data_bus_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              cs,
    output logic              we,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_BUS_WRITE,
    input  logic [DATA_W-1:0] Data_BUS_READ
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(BURST_MAX - 1);

    state_e           state;
    logic             last_owner;
    logic [CNT_W-1:0] burst_cnt;
    logic             rd_pend;
    logic             rd_tag;

    // An access happens in any cycle where the owner is also requesting.
    logic acc0;
    logic acc1;

    assign gnt0 = (state == StOwn0);
    assign gnt1 = (state == StOwn1);
    assign acc0 = gnt0 & req0;
    assign acc1 = gnt1 & req1;

    // Slave-side mux. The bus is driven to all-zeros whenever no access is in progress.
    always_comb begin
        cs             = 1'b0;
        we             = 1'b0;
        ADDR           = '0;
        Data_BUS_WRITE = '0;
        if (acc0) begin
            cs             = 1'b1;
            we             = we0;
            ADDR           = addr0;
            Data_BUS_WRITE = wdata0;
        end else if (acc1) begin
            cs             = 1'b1;
            we             = we1;
            ADDR           = addr1;
            Data_BUS_WRITE = wdata1;
        end
    end

    // Read return. rd_tag records which master issued the read. This keeps the return
    // path correct even when ownership changes on the same edge.
    assign rvalid0 = rd_pend & ~rd_tag;
    assign rvalid1 = rd_pend & rd_tag;
    assign rdata0  = rvalid0 ? Data_BUS_READ : '0;
    assign rdata1  = rvalid1 ? Data_BUS_READ : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            last_owner <= 1'b1;   // master 0 wins the first tie
            burst_cnt  <= '0;
            rd_pend    <= 1'b0;
            rd_tag     <= 1'b0;
        end else begin
            rd_pend <= (acc0 & ~we0) | (acc1 & ~we1);
            rd_tag  <= acc1;

            unique case (state)
                StIdle: begin
                    if (req0 && req1) begin
                        state <= last_owner ? StOwn0 : StOwn1;
                    end else if (req0) begin
                        state <= StOwn0;
                    end else if (req1) begin
                        state <= StOwn1;
                    end
                end

                StOwn0: begin
                    if (!req0) begin
                        // Dropping the request forfeits ownership.
                        state      <= req1 ? StOwn1 : StIdle;
                        last_owner <= 1'b0;
                        burst_cnt  <= '0;
                    end else if (burst_cnt == CntLast) begin
                        // Burst limit: hand over with no dead cycle if master 1 waits,
                        // otherwise keep the bus and let the counter wrap.
                        burst_cnt <= '0;
                        if (req1) begin
                            state      <= StOwn1;
                            last_owner <= 1'b0;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end

                StOwn1: begin
                    if (!req1) begin
                        state      <= req0 ? StOwn0 : StIdle;
                        last_owner <= 1'b1;
                        burst_cnt  <= '0;
                    end else if (burst_cnt == CntLast) begin
                        burst_cnt <= '0;
                        if (req0) begin
                            state      <= StOwn0;
                            last_owner <= 1'b1;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [9:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        cs, we;
    logic [9:0]  ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ = '0;

    int checks = 0;
    int errors = 0;

    data_bus_arbiter #(
        .ADDR_W(10), .DATA_W(32), .BURST_MAX(4), .CNT_W(3)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .cs(cs), .we(we), .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE),
        .Data_BUS_READ(Data_BUS_READ)
    );

    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #13;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL reset_gnt got %b%b exp 00", gnt0, gnt1);
        end
        checks++; if (cs !== 1'b0 || we !== 1'b0 || ADDR !== 10'h0 || Data_BUS_WRITE !== 32'h0) begin
            errors++; $display("FAIL reset_bus got cs=%b we=%b addr=%h wd=%h exp zeros",
                               cs, we, ADDR, Data_BUS_WRITE);
        end
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid got %b%b exp 00", rvalid0, rvalid1);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read_stream();
        apply_reset();
        req0 = 1; we0 = 0; addr0 = 10'h012; Data_BUS_READ = 32'hDEADBEEF;
        #1;
        checks++; if (gnt0 !== 1'b0 || cs !== 1'b0) begin
            errors++; $display("FAIL rd_latency got gnt0=%b cs=%b exp 0 0", gnt0, cs);
        end
        tick();
        checks++; if (gnt0 !== 1'b1 || cs !== 1'b1 || ADDR !== 10'h012 || we !== 1'b0) begin
            errors++; $display("FAIL rd_first got gnt0=%b cs=%b addr=%h we=%b exp 1 1 012 0",
                               gnt0, cs, ADDR, we);
        end
        checks++; if (rvalid0 !== 1'b0) begin
            errors++; $display("FAIL rd_first_rvalid got %b exp 0", rvalid0);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rdata1 !== 32'h0) begin
                errors++; $display("FAIL rd_stream[%0d] got rv=%b d0=%h d1=%h exp 1 deadbeef 0",
                                   k, rvalid0, rdata0, rdata1);
            end
            checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || cs !== 1'b1 || rvalid1 !== 1'b0) begin
                errors++; $display("FAIL rd_own[%0d] got g0=%b g1=%b cs=%b rv1=%b exp 1 0 1 0",
                                   k, gnt0, gnt1, cs, rvalid1);
            end
        end
        req0 = 0;
        #1;
        checks++; if (cs !== 1'b0) begin
            errors++; $display("FAIL rd_drop_cs got %b exp 0", cs);
        end
        tick();
        checks++; if (gnt0 !== 1'b0 || rvalid0 !== 1'b0) begin
            errors++; $display("FAIL rd_drop_idle got g0=%b rv0=%b exp 0 0", gnt0, rvalid0);
        end
    endtask

    task automatic test_contention();
        logic exp_g0;
        apply_reset();
        req0 = 1; we0 = 1; addr0 = 10'h001; wdata0 = 32'h11;
        req1 = 1; we1 = 1; addr1 = 10'h002; wdata1 = 32'h22;
        tick();
        for (int k = 0; k < 16; k++) begin
            exp_g0 = ((k / 4) % 2) == 0;
            checks++; if (gnt0 !== exp_g0 || gnt1 !== !exp_g0 || cs !== 1'b1) begin
                errors++; $display("FAIL rr_owner[%0d] got g0=%b g1=%b cs=%b exp %b %b 1",
                                   k, gnt0, gnt1, cs, exp_g0, !exp_g0);
            end
            checks++; if (ADDR !== (exp_g0 ? 10'h001 : 10'h002)) begin
                errors++; $display("FAIL rr_addr[%0d] got %h exp %h", k, ADDR,
                                   exp_g0 ? 10'h001 : 10'h002);
            end
            tick();
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_burst_wrap();
        apply_reset();
        req1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 32'h00000055;
        tick();
        for (int k = 0; k < 10; k++) begin
            checks++; if (gnt1 !== 1'b1 || cs !== 1'b1 || we !== 1'b1 || ADDR !== 10'h3FF
                          || Data_BUS_WRITE !== 32'h55) begin
                errors++; $display("FAIL wr_wrap[%0d] got g1=%b cs=%b we=%b a=%h wd=%h exp 1 1 1 3ff 55",
                                   k, gnt1, cs, we, ADDR, Data_BUS_WRITE);
            end
            checks++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin
                errors++; $display("FAIL wr_rvalid[%0d] got %b%b exp 00", k, rvalid1, rvalid0);
            end
            tick();
        end
        req1 = 0;
    endtask

    task automatic test_drop_req();
        apply_reset();
        req0 = 1; we0 = 1; addr0 = 10'h005;
        tick();
        tick();
        tick();
        req0 = 0;
        #1;
        checks++; if (cs !== 1'b0) begin
            errors++; $display("FAIL drop_cs got %b exp 0", cs);
        end
        tick();
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || cs !== 1'b0) begin
            errors++; $display("FAIL drop_idle got g0=%b g1=%b cs=%b exp 0 0 0", gnt0, gnt1, cs);
        end
        req0 = 1; req1 = 1; we1 = 1; addr1 = 10'h077;
        tick();
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ADDR !== 10'h077) begin
            errors++; $display("FAIL drop_tie got g0=%b g1=%b a=%h exp 0 1 077", gnt0, gnt1, ADDR);
        end
        req0 = 0; req1 = 0;
        tick();
    endtask

    task automatic test_read_handover();
        apply_reset();
        Data_BUS_READ = 32'hA5A50001;
        req0 = 1; we0 = 0; addr0 = 10'h020;
        req1 = 1; we1 = 1; addr1 = 10'h030; wdata1 = 32'h99;
        tick();
        tick();
        tick();
        tick();
        checks++; if (gnt0 !== 1'b1 || ADDR !== 10'h020 || we !== 1'b0) begin
            errors++; $display("FAIL ho_4th got g0=%b a=%h we=%b exp 1 020 0", gnt0, ADDR, we);
        end
        tick();
        checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || cs !== 1'b1 || ADDR !== 10'h030) begin
            errors++; $display("FAIL ho_gnt1 got g0=%b g1=%b cs=%b a=%h exp 0 1 1 030",
                               gnt0, gnt1, cs, ADDR);
        end
        checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hA5A50001) begin
            errors++; $display("FAIL ho_rvalid0 got rv=%b d=%h exp 1 a5a50001", rvalid0, rdata0);
        end
        checks++; if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin
            errors++; $display("FAIL ho_rvalid1 got rv=%b d=%h exp 0 0", rvalid1, rdata1);
        end
        tick();
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL ho_after got %b%b exp 00", rvalid0, rvalid1);
        end
        req0 = 0; req1 = 0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        Data_BUS_READ = 32'h12345678;
        req0 = 1; we0 = 0; addr0 = 10'h012;
        tick();
        tick();
        checks++; if (rvalid0 !== 1'b1) begin
            errors++; $display("FAIL rst_pre got rv0=%b exp 1", rvalid0);
        end
        #1;
        reset = 1'b1;
        req1 = 1;
        #1;
        checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0
                      || cs !== 1'b0) begin
            errors++; $display("FAIL rst_async got g0=%b g1=%b rv0=%b rv1=%b cs=%b exp all 0",
                               gnt0, gnt1, rvalid0, rvalid1, cs);
        end
        #2;
        reset = 1'b0;
        tick();
        checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL rst_late_rvalid got %b%b exp 00", rvalid0, rvalid1);
        end
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++; $display("FAIL rst_tie got g0=%b g1=%b exp 1 0", gnt0, gnt1);
        end
        req0 = 0; req1 = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_stream();
        test_contention();
        test_burst_wrap();
        test_drop_req();
        test_read_handover();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
